// File: rtl/gemm_pkg.sv
// Shared definitions for the GeMM result drain: default tile geometry and drain FSM states.
package gemm_pkg;

  localparam int unsigned GemmOutDataWidth = 32;
  localparam int unsigned GemmNumPeM       = 4;
  localparam int unsigned GemmNumPeN       = 4;

  localparam int unsigned BeatWidth    = GemmNumPeN * GemmOutDataWidth;
  localparam int unsigned BeatIdxWidth = $clog2(GemmNumPeM);

  typedef enum logic {
    IDLE,
    SEND
  } drain_state_e;

endpackage

// File: rtl/gemm_tile_fifo.sv
// Generic synchronous FIFO with wrap-around pointers, occupancy count and full/empty flags.
module gemm_tile_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full_o  = (count_q == CntW'(Depth));
    empty_o = (count_q == '0);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    rdata_o = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gemm_c_drain.sv
// Buffers whole GeMM output tiles and serializes each into row beats for the C memory port.
module gemm_c_drain
  import gemm_pkg::*;
#(
  parameter int unsigned OutDataWidth = GemmOutDataWidth,
  parameter int unsigned NumPE_M      = GemmNumPeM,
  parameter int unsigned NumPE_N      = GemmNumPeN,
  parameter int unsigned AddrWidth    = 16,
  parameter int unsigned FifoDepth    = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    tile_valid_i,
  output logic                                    tile_ready_o,
  input  logic [NumPE_M*NumPE_N*OutDataWidth-1:0] tile_data_i,
  input  logic [AddrWidth-1:0]                    tile_addr_i,
  output logic                                    mem_valid_o,
  input  logic                                    mem_ready_i,
  output logic [AddrWidth-1:0]                    mem_addr_o,
  output logic [NumPE_N*OutDataWidth-1:0]         mem_wdata_o,
  output logic                                    busy_o,
  output logic                                    overflow_o,
  output logic [AddrWidth-1:0]                    tile_count_o
);

  localparam int unsigned RowW   = NumPE_N * OutDataWidth;
  localparam int unsigned TileW  = NumPE_M * RowW;
  localparam int unsigned IdxW   = $clog2(NumPE_M);
  localparam int unsigned EntryW = AddrWidth + TileW;
  localparam int unsigned CntW   = $clog2(FifoDepth + 1);
  localparam logic [IdxW-1:0] LastBeat = IdxW'(NumPE_M - 1);

  drain_state_e         state_q;
  logic [IdxW-1:0]      beat_q;
  logic                 ready_en_q;
  logic                 busy_q;
  logic                 overflow_q;
  logic [AddrWidth-1:0] tile_count_q;

  logic                 push;
  logic                 pop;
  logic                 last_beat;
  logic                 more_after_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CntW-1:0]      fifo_count;
  logic [EntryW-1:0]    head;
  logic [TileW-1:0]     head_data;
  logic [AddrWidth-1:0] head_addr;
  logic [RowW-1:0]      head_row;

  gemm_tile_fifo #(
    .Width(EntryW),
    .Depth(FifoDepth)
  ) u_tile_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i({tile_addr_i, tile_data_i}),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    tile_ready_o   = ready_en_q && !fifo_full;
    push           = tile_valid_i && tile_ready_o;
    last_beat      = (beat_q == LastBeat);
    pop            = (state_q == SEND) && mem_ready_i && last_beat;
    more_after_pop = (fifo_count > CntW'(1)) || push;
    head_data      = head[TileW-1:0];
    head_addr      = head[EntryW-1 -: AddrWidth];
    head_row       = '0;
    for (int unsigned r = 0; r < NumPE_M; r++) begin
      if (beat_q == IdxW'(r)) begin
        head_row = head_data[r*RowW +: RowW];
      end
    end
  end

  // Address and data are zeroed whenever no beat is offered so that reset and idle look identical.
  always_comb begin
    mem_valid_o  = (state_q == SEND);
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (mem_valid_o) begin
      mem_addr_o  = (head_addr << IdxW) + AddrWidth'(beat_q);
      mem_wdata_o = head_row;
    end
    busy_o       = busy_q;
    overflow_o   = overflow_q;
    tile_count_o = tile_count_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      ready_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      tile_count_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (tile_valid_i && !tile_ready_o) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        // Entering SEND on the push edge itself gives a valid beat in the very next cycle.
        IDLE: begin
          beat_q <= '0;
          if (!fifo_empty || push) begin
            state_q <= SEND;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (mem_ready_i) begin
            if (last_beat) begin
              beat_q       <= '0;
              tile_count_q <= tile_count_q + AddrWidth'(1);
              if (!more_after_pop) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              beat_q <= beat_q + IdxW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
